// File: rtl/ldpc_cn.sv
// ldpc_cn: min-sum check-node processor with one registered output stage.
// Takes six sign-magnitude variable-to-check messages. Each output k gets the
// XOR of the other five signs and the minimum of the other five magnitudes.
// Optional feature macro: CN_OFFSET_EN selects offset min-sum, which subtracts
// OFFSET from every output magnitude and saturates the result at zero.
module ldpc_cn #(
  parameter int W      = 11,
  parameter int OFFSET = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] msg_in_1,
  input  logic [W-1:0] msg_in_2,
  input  logic [W-1:0] msg_in_3,
  input  logic [W-1:0] msg_in_4,
  input  logic [W-1:0] msg_in_5,
  input  logic [W-1:0] msg_in_6,
  output logic         out_valid,
  output logic [W-1:0] msg_out_1,
  output logic [W-1:0] msg_out_2,
  output logic [W-1:0] msg_out_3,
  output logic [W-1:0] msg_out_4,
  output logic [W-1:0] msg_out_5,
  output logic [W-1:0] msg_out_6
);

  localparam int M = W - 1;

  // An offset that does not fit in the magnitude field is meaningless
  if (OFFSET < 0 || OFFSET >= (1 << M)) begin : g_bad_offset
    $error("ldpc_cn: OFFSET must fit in W-1 unsigned bits");
  end

  logic [M-1:0] mag [6];
  logic [5:0]   sgn;
  logic [M-1:0] min1;
  logic [M-1:0] min2;
  logic [2:0]   idx;
  logic         s_all;
  logic [W-1:0] nxt [6];
  logic [W-1:0] msg_q [6];

  assign mag[0] = msg_in_1[M-1:0];
  assign mag[1] = msg_in_2[M-1:0];
  assign mag[2] = msg_in_3[M-1:0];
  assign mag[3] = msg_in_4[M-1:0];
  assign mag[4] = msg_in_5[M-1:0];
  assign mag[5] = msg_in_6[M-1:0];
  assign sgn    = {msg_in_6[W-1], msg_in_5[W-1], msg_in_4[W-1],
                   msg_in_3[W-1], msg_in_2[W-1], msg_in_1[W-1]};

  // The -0 inputs keep their sign bit here, so they still flip the parity
  assign s_all = ^sgn;

  // Smallest magnitude and its position; strict compare keeps the lowest index on ties
  always_comb begin
    min1 = mag[0];
    idx  = 3'd0;
    for (int k = 1; k < 6; k++) begin
      if (mag[k] < min1) begin
        min1 = mag[k];
        idx  = 3'(k);
      end
    end
  end

  // Second minimum: smallest of the five inputs other than idx, equals min1 on a tie
  always_comb begin
    min2 = '1;
    for (int k = 0; k < 6; k++) begin
      if (3'(k) != idx && mag[k] < min2) begin
        min2 = mag[k];
      end
    end
  end

  // Per-output magnitude select, optional offset, sign, and zero normalization
  always_comb begin
    logic [M-1:0] omag;
    logic         osgn;
    omag = '0;
    osgn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      omag = (3'(k) == idx) ? min2 : min1;
`ifdef CN_OFFSET_EN
      omag = (omag > M'(OFFSET)) ? (omag - M'(OFFSET)) : '0;
`endif
      osgn   = s_all ^ sgn[k];
      nxt[k] = (omag == '0) ? '0 : {osgn, omag};
    end
  end

  // Output register bank: capture on in_valid, otherwise hold; reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        msg_q[k] <= '0;
      end
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < 6; k++) begin
          msg_q[k] <= nxt[k];
        end
      end
    end
  end

  assign msg_out_1 = msg_q[0];
  assign msg_out_2 = msg_q[1];
  assign msg_out_3 = msg_q[2];
  assign msg_out_4 = msg_q[3];
  assign msg_out_5 = msg_q[4];
  assign msg_out_6 = msg_q[5];

endmodule

// File: tb/tb_ldpc_cn.sv
// tb_ldpc_cn: self-checking bench for ldpc_cn. A behavioural model computes each
// output directly as "min and sign-parity over the other five inputs", a compare
// process checks every cycle, and literal sets pin both the model and the DUT.
module tb_ldpc_cn;

  localparam int W      = 11;
  localparam int M      = W - 1;
  localparam int OFFSET = 1;
  localparam int NEG    = 1 << M;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] din  [6];
  logic [W-1:0] dout [6];
  logic         out_valid;

  logic         exp_valid;
  logic [W-1:0] exp_out  [6];
  logic [W-1:0] mdl_next [6];
  logic         check_en = 1'b0;

  int checks = 0;
  int errors = 0;

  ldpc_cn #(.W(W), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .msg_in_1(din[0]), .msg_in_2(din[1]), .msg_in_3(din[2]),
    .msg_in_4(din[3]), .msg_in_5(din[4]), .msg_in_6(din[5]),
    .out_valid(out_valid),
    .msg_out_1(dout[0]), .msg_out_2(dout[1]), .msg_out_3(dout[2]),
    .msg_out_4(dout[3]), .msg_out_5(dout[4]), .msg_out_6(dout[5])
  );

  always #5 clk = ~clk;

  // Reference: each output is the min magnitude and sign parity of the other five
  function automatic void model(input logic [W-1:0] in_m [6], output logic [W-1:0] out_m [6]);
    for (int k = 0; k < 6; k++) begin
      int m;
      int s;
      m = NEG;
      s = 0;
      for (int j = 0; j < 6; j++) begin
        if (j != k) begin
          if (int'(in_m[j][M-1:0]) < m) m = int'(in_m[j][M-1:0]);
          s = s ^ int'(in_m[j][W-1]);
        end
      end
`ifdef CN_OFFSET_EN
      m = (m > OFFSET) ? m - OFFSET : 0;
`endif
      out_m[k] = (m == 0) ? W'(0) : W'(s * NEG + m);
    end
  endfunction

  always_comb model(din, mdl_next);

  // Expected output state: one-cycle latency, hold when idle, cleared by reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_valid <= 1'b0;
      for (int k = 0; k < 6; k++) exp_out[k] <= '0;
    end else begin
      exp_valid <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < 6; k++) exp_out[k] <= mdl_next[k];
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model, away from the rising edge
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("out_valid", int'(out_valid), int'(exp_valid));
      for (int k = 0; k < 6; k++) begin
        checkOutput($sformatf("msg_out_%0d", k + 1), int'(dout[k]), int'(exp_out[k]));
      end
    end
  end

  task automatic applyStimulus(input logic v, input int a, input int b, input int c,
                               input int d, input int e, input int f);
    in_valid = v;
    din[0] = W'(a); din[1] = W'(b); din[2] = W'(c);
    din[3] = W'(d); din[4] = W'(e); din[5] = W'(f);
  endtask

  task automatic checkSet(input string name, input logic v, input int a, input int b,
                          input int c, input int d, input int e, input int f);
    int lit [6];
    lit = '{a, b, c, d, e, f};
    checkOutput({name, " valid"}, int'(out_valid), int'(v));
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("%s out%0d", name, k + 1), int'(dout[k]), lit[k]);
    end
  endtask

  initial begin
    logic [W-1:0] pin_in  [6];
    logic [W-1:0] pin_out [6];
    int           pin_lit [6];

    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1 check_en = 1'b1;

    // Pin the model itself against hand-computed values
    pin_in = '{W'(53), W'(90), W'(40), W'(178), W'(169), W'(77)};
    model(pin_in, pin_out);
`ifdef CN_OFFSET_EN
    pin_lit = '{39, 39, 52, 39, 39, 39};
`else
    pin_lit = '{40, 40, 53, 40, 40, 40};
`endif
    for (int k = 0; k < 6; k++) checkOutput($sformatf("model pin %0d", k + 1), int'(pin_out[k]), pin_lit[k]);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed back-to-back sets, each checked against literals one cycle later
    applyStimulus(1'b1, 53, 90, 40, 178, 169, 77);
    @(negedge clk);
`ifdef CN_OFFSET_EN
    checkSet("allpos", 1'b1, 39, 39, 52, 39, 39, 39);
`else
    checkSet("allpos", 1'b1, 40, 40, 53, 40, 40, 40);
`endif
    applyStimulus(1'b1, 53, 90, 40, NEG + 178, 169, 77);
    @(negedge clk);
`ifdef CN_OFFSET_EN
    checkSet("oneneg", 1'b1, NEG + 39, NEG + 39, NEG + 52, 39, NEG + 39, NEG + 39);
`else
    checkSet("oneneg", 1'b1, NEG + 40, NEG + 40, NEG + 53, 40, NEG + 40, NEG + 40);
`endif
    applyStimulus(1'b1, 7, 7, 7, 7, 7, 7);
    @(negedge clk);
`ifdef CN_OFFSET_EN
    checkSet("tie7", 1'b1, 6, 6, 6, 6, 6, 6);
`else
    checkSet("tie7", 1'b1, 7, 7, 7, 7, 7, 7);
`endif
    applyStimulus(1'b1, 0, 5, 6, 7, 8, 9);
    @(negedge clk);
`ifdef CN_OFFSET_EN
    checkSet("zero", 1'b1, 4, 0, 0, 0, 0, 0);
`else
    checkSet("zero", 1'b1, 5, 0, 0, 0, 0, 0);
`endif
    applyStimulus(1'b1, NEG, 5, 6, 7, 8, 9);
    @(negedge clk);
`ifdef CN_OFFSET_EN
    checkSet("negzero", 1'b1, 4, 0, 0, 0, 0, 0);
`else
    checkSet("negzero", 1'b1, 5, 0, 0, 0, 0, 0);
`endif
    applyStimulus(1'b1, 1, 1, 1, 1, 1, 1);
    @(negedge clk);
`ifdef CN_OFFSET_EN
    checkSet("ones", 1'b1, 0, 0, 0, 0, 0, 0);
`else
    checkSet("ones", 1'b1, 1, 1, 1, 1, 1, 1);
`endif

    // Idle cycle with junk inputs: outputs hold, valid drops
    applyStimulus(1'b0, 300, NEG + 2, 3, 4, 5, 6);
    @(negedge clk);
`ifdef CN_OFFSET_EN
    checkSet("hold", 1'b0, 0, 0, 0, 0, 0, 0);
`else
    checkSet("hold", 1'b0, 1, 1, 1, 1, 1, 1);
`endif

    // Asynchronous reset between edges with a result in flight
    applyStimulus(1'b1, 53, 90, 40, 178, 169, 77);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkSet("asyncrst", 1'b0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized streaming with occasional idle cycles and narrow magnitude ranges
    repeat (1500) begin
      int narrow;
      narrow = int'($urandom_range(0, 2));
      in_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 6; k++) begin
        int m;
        m = (narrow == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NEG - 1));
        din[k] = W'(int'($urandom_range(0, 1)) * NEG + m);
      end
      @(negedge clk);
    end

    in_valid = 1'b0;
    @(negedge clk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldpc_cn.md
# ldpc_cn

Min-sum check-node processor for the LDPC decoder datapath. It takes six sign-magnitude variable-to-check messages and produces six check-to-variable messages. Each output carries the product of the other five signs and the minimum of the other five magnitudes. The block sits between the variable-node array and the message memory, and has a single registered pipeline stage. The module name is `ldpc_cn`.

## Interface
Parameters:
- `W`, 11: message width; bit W-1 is the sign (1 = negative), bits W-2:0 are the unsigned magnitude.
- `OFFSET`, 1: magnitude offset; used only when `CN_OFFSET_EN` is defined.

Ports:
- `clk` input 1: sole clock, rising-edge active.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: the `msg_in_*` ports carry a valid message set this cycle.
- `msg_in_1` … `msg_in_6` input W each: incoming messages, sign-magnitude.
- `out_valid` output 1: the `msg_out_*` ports were updated by the last edge.
- `msg_out_1` … `msg_out_6` output W each: outgoing messages, sign-magnitude; `msg_out_k` pairs with `msg_in_k`.

## Operation
- Magnitudes:
  - `mag_k` is `msg_in_k[W-2:0]` and `sgn_k` is `msg_in_k[W-1]`.
  - `min1` is the smallest `mag_k`, and `idx` is its index.
  - On ties, `idx` is the lowest index.
  - `min2` is the smallest magnitude among the other five inputs, so `min2 = min1` when the minimum is tied.
- Output magnitude:
  - `omag_k` is `min2` when `k == idx`, else `min1`.
- Output sign:
  - `S` is the XOR of all six `sgn_k`.
  - `osgn_k = S ^ sgn_k`, the XOR of the other five signs.
- Zero normalization:
  - If the final output magnitude is 0, the output word is all-zero (sign forced to 0).
  - Inputs of -0 still contribute their sign bit to `S`.
- Width rules:
  - All arithmetic is unsigned over W-1 bits.
  - There is no overflow, because outputs never exceed an input magnitude.
- Pipeline:
  - The whole min/sign computation is combinational from the inputs.
  - The results are captured in one output register bank.

## Timing
- Reset:
  - While `rst` is high, all `msg_out_*` are 0 and `out_valid` is 0, asynchronously.
  - Reset asserted mid-operation discards the in-flight result.
- Latency: one cycle. A set sampled at rising edge N with `in_valid=1` appears on `msg_out_*` after edge N, and `out_valid=1` for that cycle.
- Holding: if `in_valid=0` at an edge, `msg_out_*` hold their previous values and `out_valid` goes to 0.
- Throughput: one message set per cycle. Back-to-back `in_valid` gives back-to-back `out_valid`.
- Flow control: there is no stall or ready. The consumer must accept every output cycle.

## Configuration
- `CN_OFFSET_EN` defined (offset min-sum):
  - `omag_k = max(omag_k - OFFSET, 0)`, saturating at 0.
  - Zero normalization is applied after the offset.
- `CN_OFFSET_EN` undefined: plain min-sum, and `OFFSET` is ignored.
- The pipeline depth and interface are identical in both builds.

## Test plan
All values are decimal; the default build is used unless stated.
- **Reset:** assert `rst` asynchronously mid-stream, between clock edges → all outputs and `out_valid` are 0 immediately, with no clock required.
- **All-positive set:** inputs 53, 90, 40, 178, 169, 77 with `in_valid=1` → one cycle later outputs are 40, 40, 53, 40, 40, 40 and `out_valid=1`.
- **One negative input:** same set as the all-positive case but `msg_in_4 = 1024+178` →
  - `msg_out_4 = 40`;
  - `msg_out_3 = 1024+53`;
  - all other outputs are `1024+40`.
- **Tie and zero:**
  - All inputs 7 → all outputs 7.
  - `msg_in_1 = 0`, others 5..9 → `msg_out_1 = 5`, outputs 2..6 are 0 with sign clear, even if `msg_in_1 = 1024`.
- **Hold and streaming:**
  - Three consecutive valid sets → three consecutive correct outputs.
  - Then `in_valid=0` → outputs hold and `out_valid` drops.
- **Offset build** (`CN_OFFSET_EN`, `OFFSET=1`):
  - The all-positive set → 39, 39, 52, 39, 39, 39.
  - All inputs 1 → all outputs 0.
